// File: rtl/pipeline_debug_ctrl_pkg.sv
// Shared constants and the controller state encoding for the pipeline debug controller.
package debug_ctrl_pkg;

    localparam logic [7:0]  CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  CMD_RUN   = 8'h52;
    localparam logic [7:0]  CMD_STEP  = 8'h53;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L_CNT0,
        S_L_CNT1,
        S_L_DATA,
        S_WRITE,
        S_CPU_RST,
        S_RUN,
        S_STEP
    } state_t;

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// Host byte stream plus instruction-memory write port of the debug controller.
interface pipeline_debug_ctrl_if;

    // A byte transfers on a rising edge where i_cmd_valid and o_cmd_ready are both 1;
    // the host holds i_cmd_byte stable while valid is high and ready is low.
    logic        i_cmd_valid;
    logic [7:0]  i_cmd_byte;
    logic        o_cmd_ready;
    logic        o_inst_mem_wr_en;
    logic [31:0] o_inst_mem_addr;
    logic [31:0] o_inst_mem_data;

    modport master (
        output i_cmd_valid, i_cmd_byte,
        input  o_cmd_ready, o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data
    );

    modport slave (
        input  i_cmd_valid, i_cmd_byte,
        output o_cmd_ready, o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data
    );

endinterface

// File: rtl/pipeline_debug_ctrl_asm.sv
// Collects accepted bytes little-endian into a 32-bit word; word_done marks the 4th byte.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] byte_cnt;

    assign word_done = byte_valid && !clear && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= 2'd0;
            word     <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            word     <= 32'd0;
        end else if (byte_valid) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt                      <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Byte-command controller: loads program words into instruction memory and gates the
// pipeline's reset and clock enable for run and single-step execution.
module pipeline_debug_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned RST_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_debug_ctrl_if.slave  cmd,
    output logic                  o_cpu_reset,
    output logic                  o_cpu_enable,
    input  logic                  i_halt,
    output logic                  o_halted,
    output logic                  o_err,
    output logic [31:0]           o_cycle_count,
    output state_t                o_dbg_state
);

    state_t      state;
    logic        loaded;
    logic        cmd_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [15:0] word_idx_next;
    logic [7:0]  rst_timer;
    logic        accept;
    logic        asm_clear;
    logic        word_done;
    logic [31:0] asm_word;
    logic [15:0] load_count;
    logic        enter_rst;

    assign accept        = cmd.i_cmd_valid && cmd_ready;
    // The count bytes share the assembler; it is flushed before data bytes start.
    assign asm_clear     = (state == S_IDLE) || (state == S_L_CNT1);
    assign load_count    = {cmd.i_cmd_byte, asm_word[7:0]};
    assign word_idx_next = word_idx + 16'd1;
    assign enter_rst     = ((state == S_L_CNT1) && accept && (load_count == 16'd0)) ||
                           ((state == S_WRITE) && (word_idx_next == word_count));

    byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (accept),
        .byte_in    (cmd.i_cmd_byte),
        .word       (asm_word),
        .word_done  (word_done)
    );

    assign cmd.o_cmd_ready      = cmd_ready;
    assign cmd.o_inst_mem_wr_en = wr_en;
    assign cmd.o_inst_mem_addr  = wr_addr;
    assign cmd.o_inst_mem_data  = asm_word;
    assign o_dbg_state          = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            loaded        <= 1'b0;
            cmd_ready     <= 1'b1;
            wr_en         <= 1'b0;
            wr_addr       <= 32'd0;
            word_count    <= 16'd0;
            word_idx      <= 16'd0;
            rst_timer     <= 8'd0;
            o_cpu_reset   <= 1'b1;
            o_cpu_enable  <= 1'b0;
            o_halted      <= 1'b0;
            o_err         <= 1'b0;
            o_cycle_count <= 32'd0;
        end else begin
            wr_en <= 1'b0;
            if (o_cpu_enable && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd.i_cmd_byte == CMD_LOAD) begin
                            state       <= S_L_CNT0;
                            o_err       <= 1'b0;
                            o_cpu_reset <= 1'b1;
                        end else if ((cmd.i_cmd_byte == CMD_RUN) || (cmd.i_cmd_byte == CMD_STEP)) begin
                            if (!loaded || o_halted) begin
                                o_err <= 1'b1;
                            end else begin
                                state        <= (cmd.i_cmd_byte == CMD_RUN) ? S_RUN : S_STEP;
                                cmd_ready    <= 1'b0;
                                o_cpu_enable <= 1'b1;
                            end
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_L_CNT0: begin
                    if (accept) state <= S_L_CNT1;
                end
                S_L_CNT1: begin
                    // Oversized loads abort before any data byte; the old program stays usable.
                    if (accept && (load_count != 16'd0)) begin
                        if ({16'd0, load_count} > MEM_DEPTH) begin
                            o_err       <= 1'b1;
                            state       <= S_IDLE;
                            o_cpu_reset <= !loaded;
                        end else begin
                            word_count <= load_count;
                            word_idx   <= 16'd0;
                            state      <= S_L_DATA;
                        end
                    end
                end
                S_L_DATA: begin
                    if (word_done) begin
                        state     <= S_WRITE;
                        cmd_ready <= 1'b0;
                        wr_en     <= 1'b1;
                        wr_addr   <= 32'(word_idx) * ADDR_STEP;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx_next;
                    if (word_idx_next != word_count) begin
                        state     <= S_L_DATA;
                        cmd_ready <= 1'b1;
                    end
                end
                S_CPU_RST: begin
                    if (rst_timer == 8'd0) begin
                        state       <= S_IDLE;
                        o_cpu_reset <= 1'b0;
                        cmd_ready   <= 1'b1;
                    end else begin
                        rst_timer <= rst_timer - 8'd1;
                    end
                end
                S_RUN: begin
                    if (i_halt) begin
                        o_halted     <= 1'b1;
                        state        <= S_IDLE;
                        o_cpu_enable <= 1'b0;
                        cmd_ready    <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (i_halt) o_halted <= 1'b1;
                    state        <= S_IDLE;
                    o_cpu_enable <= 1'b0;
                    cmd_ready    <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            if (enter_rst) begin
                state         <= S_CPU_RST;
                cmd_ready     <= 1'b0;
                rst_timer     <= 8'(RST_CYC - 1);
                o_cycle_count <= 32'd0;
                o_halted      <= 1'b0;
                loaded        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench: reset and error vector table, hand-written load/run/step sequences,
// and randomized command streams scored against a transaction-level model.
module tb_pipeline_debug_ctrl;
    import debug_ctrl_pkg::*;

    localparam int unsigned MEM_DEPTH = 256;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_halt = 1'b0;
    logic        cpu_reset, cpu_enable, halted, err;
    logic [31:0] cycle_count;
    state_t      dbg_state;

    pipeline_debug_ctrl_if bus ();

    pipeline_debug_ctrl #(.MEM_DEPTH(MEM_DEPTH), .RST_CYC(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (bus),
        .o_cpu_reset   (cpu_reset),
        .o_cpu_enable  (cpu_enable),
        .i_halt        (i_halt),
        .o_halted      (halted),
        .o_err         (err),
        .o_cycle_count (cycle_count),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] load_words[$];

    // transaction-level model state
    bit          m_loaded, m_halted, m_err;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- scoreboard on the write port ----------------
    always @(negedge clk) begin
        if (reset && (bus.o_inst_mem_wr_en === 1'b1)) begin
            n_wr++;
            chk("ready_low_in_write", 64'(bus.o_cmd_ready), 64'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.o_inst_mem_addr, bus.o_inst_mem_data);
            end else begin
                chk("write_addr_data", {bus.o_inst_mem_addr, bus.o_inst_mem_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit drop);
        bit done = 1'b0;
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_byte  = b;
        for (int i = 0; i < 64 && !done; i++) begin
            if (bus.o_cmd_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) fail_now($sformatf("send_byte_0x%0h", b));
        #1;
        if (drop || !done) bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit fin = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (dbg_state == S_IDLE) fin = 1'b1;
        end
        if (!fin) fail_now("wait_idle");
    endtask

    // Sends a command byte, answers enable cycles (halt raised in the halt_k-th one),
    // and reports how many cycles the pipeline was enabled.
    task automatic issue(input logic [7:0] b, input int halt_k, output int n_en);
        bit fin = 1'b0;
        n_en = 0;
        send_byte(b, 1'b1);
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (cpu_enable) begin
                n_en++;
                i_halt = (n_en == halt_k);
            end else begin
                i_halt = 1'b0;
                if (dbg_state == S_IDLE) fin = 1'b1;
            end
        end
        i_halt = 1'b0;
        if (!fin) fail_now("issue_return_idle");
    endtask

    task automatic do_load(input logic [15:0] n);
        bit ok;
        ok = (n != 16'd0) && (32'(n) <= MEM_DEPTH);
        send_byte(CMD_LOAD, 1'b0);
        send_byte(n[7:0], 1'b0);
        send_byte(n[15:8], !ok);
        if (ok) begin
            for (int w = 0; w < int'(n); w++) begin
                exp_q.push_back({32'(w) * 32'd4, load_words[w]});
                for (int k = 0; k < 4; k++) begin
                    send_byte(load_words[w][8*k +: 8], (w == int'(n) - 1) && (k == 3));
                end
            end
        end
        wait_idle();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},     64'(bus.o_cmd_ready),      64'd1);
        chk({tag, "_wr_en"},     64'(bus.o_inst_mem_wr_en), 64'd0);
        chk({tag, "_addr"},      64'(bus.o_inst_mem_addr),  64'd0);
        chk({tag, "_data"},      64'(bus.o_inst_mem_data),  64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset),            64'd1);
        chk({tag, "_enable"},    64'(cpu_enable),           64'd0);
        chk({tag, "_halted"},    64'(halted),               64'd0);
        chk({tag, "_err"},       64'(err),                  64'd0);
        chk({tag, "_count"},     64'(cycle_count),          64'd0);
    endtask

    task automatic hard_reset(input string tag);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        i_halt          = 1'b0;
        reset           = 1'b0;
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        reset    = 1'b1;
        m_loaded = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_count  = 32'd0;
    endtask

    // ---------------- reference model ----------------
    task automatic model_load(input logic [15:0] n);
        m_err = 1'b0;
        if (32'(n) > MEM_DEPTH) begin
            m_err = 1'b1;
        end else begin
            m_loaded = 1'b1;
            m_halted = 1'b0;
            m_count  = 32'd0;
        end
    endtask

    task automatic model_cmd(input logic [7:0] b, input int halt_k, output int exp_en);
        exp_en = 0;
        if ((b == CMD_RUN) || (b == CMD_STEP)) begin
            if (!m_loaded || m_halted) begin
                m_err = 1'b1;
            end else if (b == CMD_RUN) begin
                exp_en   = halt_k;
                m_halted = 1'b1;
                m_count  = m_count + 32'(halt_k);
            end else begin
                exp_en  = 1;
                m_count = m_count + 32'd1;
                if (halt_k == 1) m_halted = 1'b1;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"},  64'(dbg_state),   64'(S_IDLE));
        chk({tag, "_err"},    64'(err),         64'(m_err));
        chk({tag, "_halted"}, 64'(halted),      64'(m_halted));
        chk({tag, "_count"},  64'(cycle_count), 64'(m_count));
        chk({tag, "_enable"}, 64'(cpu_enable),  64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         pre_load;
        logic [7:0] b;
        int         halt_k;
        bit         exp_err;
        int         exp_en;
        bit         exp_halted;
        int         exp_count;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en;
        int wr0;
        logic [7:0] rb;
        logic [15:0] rn;

        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_byte  = 8'h00;

        vecs[0] = '{1'b0, 8'h58,     0, 1'b1, 0, 1'b0, 0};
        vecs[1] = '{1'b0, CMD_RUN,   1, 1'b1, 0, 1'b0, 0};
        vecs[2] = '{1'b0, CMD_STEP,  1, 1'b1, 0, 1'b0, 0};
        vecs[3] = '{1'b0, 8'h00,     0, 1'b1, 0, 1'b0, 0};
        vecs[4] = '{1'b1, CMD_STEP,  0, 1'b0, 1, 1'b0, 1};
        vecs[5] = '{1'b1, CMD_STEP,  1, 1'b0, 1, 1'b1, 1};
        vecs[6] = '{1'b1, CMD_RUN,   1, 1'b0, 1, 1'b1, 1};
        vecs[7] = '{1'b1, CMD_RUN,   4, 1'b0, 4, 1'b1, 4};
        vecs[8] = '{1'b1, 8'hFF,     0, 1'b1, 0, 1'b0, 0};

        hard_reset("rst0");
        #1;
        check_reset_vals("rst0_released");

        for (int i = 0; i < 9; i++) begin
            hard_reset($sformatf("tbl%0d_rst", i));
            if (vecs[i].pre_load) begin
                load_words.delete();
                load_words.push_back($urandom);
                do_load(16'd1);
            end
            wr0 = n_wr;
            issue(vecs[i].b, vecs[i].halt_k, n_en);
            chk($sformatf("tbl%0d_err", i),    64'(err),         64'(vecs[i].exp_err));
            chk($sformatf("tbl%0d_en", i),     64'(n_en),        64'(vecs[i].exp_en));
            chk($sformatf("tbl%0d_halted", i), 64'(halted),      64'(vecs[i].exp_halted));
            chk($sformatf("tbl%0d_count", i),  64'(cycle_count), 64'(vecs[i].exp_count));
            chk($sformatf("tbl%0d_state", i),  64'(dbg_state),   64'(S_IDLE));
            chk($sformatf("tbl%0d_no_wr", i),  64'(n_wr - wr0),  64'd0);
        end

        // Single word load with exact CPU reset release timing.
        hard_reset("t1_rst");
        exp_q.push_back({32'd0, 32'h00094100});
        send_byte(CMD_LOAD, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h09, 1'b0);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        chk("t1_wr_en", 64'(bus.o_inst_mem_wr_en), 64'd1);
        chk("t1_cpu_reset_write", 64'(cpu_reset), 64'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("t1_rst_cyc%0d", c), 64'(cpu_reset), 64'd1);
            chk($sformatf("t1_rst_state%0d", c), 64'(dbg_state), 64'(S_CPU_RST));
        end
        @(negedge clk);
        chk("t1_cpu_reset_released", 64'(cpu_reset), 64'd0);
        chk("t1_ready_idle", 64'(bus.o_cmd_ready), 64'd1);
        issue(CMD_RUN, 5, n_en);
        chk("t1_run_en", 64'(n_en), 64'd5);
        chk("t1_halted", 64'(halted), 64'd1);

        // Three words with valid held high across the write cycles.
        hard_reset("t2_rst");
        load_words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        wr0 = n_wr;
        do_load(16'd3);
        chk("t2_wr_count", 64'(n_wr - wr0), 64'd3);
        chk("t2_cpu_reset", 64'(cpu_reset), 64'd0);

        // Three single steps.
        for (int s = 0; s < 3; s++) begin
            issue(CMD_STEP, 0, n_en);
            chk($sformatf("t3_step%0d_en", s), 64'(n_en), 64'd1);
        end
        chk("t3_count", 64'(cycle_count), 64'd3);
        chk("t3_halted", 64'(halted), 64'd0);

        // Oversized count is rejected without consuming data.
        hard_reset("t4_rst");
        wr0 = n_wr;
        send_byte(CMD_LOAD, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b1);
        @(negedge clk);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_state", 64'(dbg_state), 64'(S_IDLE));
        chk("t4_ready", 64'(bus.o_cmd_ready), 64'd1);
        chk("t4_no_wr", 64'(n_wr - wr0), 64'd0);

        // Run halted on its 10th enabled cycle, then a rejected run and a fresh load.
        hard_reset("t5_rst");
        load_words = '{32'h12345678};
        do_load(16'd1);
        issue(CMD_RUN, 10, n_en);
        chk("t5_run_en", 64'(n_en), 64'd10);
        chk("t5_halted", 64'(halted), 64'd1);
        chk("t5_count", 64'(cycle_count), 64'd10);
        issue(CMD_RUN, 10, n_en);
        chk("t5_rerun_en", 64'(n_en), 64'd0);
        chk("t5_rerun_err", 64'(err), 64'd1);
        load_words = '{32'h9ABCDEF0};
        do_load(16'd1);
        chk("t5_reload_halted", 64'(halted), 64'd0);
        chk("t5_reload_count", 64'(cycle_count), 64'd0);
        chk("t5_reload_err", 64'(err), 64'd0);

        // Reset in the middle of a data word.
        hard_reset("t6_pre");
        send_byte(CMD_LOAD, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        hard_reset("t6_mid");
        wr0 = n_wr;
        load_words = '{32'hCAFEF00D};
        do_load(16'd1);
        chk("t6_fresh_wr", 64'(n_wr - wr0), 64'd1);

        // Randomized command stream against the model.
        hard_reset("rnd_rst");
        for (int r = 0; r < 40; r++) begin
            int op;
            int k;
            int exp_en;
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    rn = 16'($urandom_range(0, 4));
                    load_words.delete();
                    for (int w = 0; w < int'(rn); w++) load_words.push_back($urandom);
                    model_load(rn);
                    do_load(rn);
                end
                1: begin
                    k = int'($urandom_range(1, 12));
                    model_cmd(CMD_RUN, k, exp_en);
                    issue(CMD_RUN, k, n_en);
                    chk($sformatf("rnd%0d_run_en", r), 64'(n_en), 64'(exp_en));
                end
                2: begin
                    k = int'($urandom_range(0, 1));
                    model_cmd(CMD_STEP, k, exp_en);
                    issue(CMD_STEP, k, n_en);
                    chk($sformatf("rnd%0d_step_en", r), 64'(n_en), 64'(exp_en));
                end
                3: begin
                    do rb = 8'($urandom_range(0, 255));
                    while ((rb == CMD_LOAD) || (rb == CMD_RUN) || (rb == CMD_STEP));
                    model_cmd(rb, 0, exp_en);
                    issue(rb, 0, n_en);
                    chk($sformatf("rnd%0d_bad_en", r), 64'(n_en), 64'(exp_en));
                end
                default: begin
                    rn = 16'($urandom_range(MEM_DEPTH + 1, 65535));
                    model_load(rn);
                    do_load(rn);
                end
            endcase
            check_model($sformatf("rnd%0d", r));
        end

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
